acc_sequencer: RTL
==================

# acc_sequencer

Instruction sequencer that sits directly upstream of the accumulator ALU. It fetches 16-bit instructions from program memory over a req/ack handshake and decodes each opcode. It then drives the ALU's operand, select and enable lines for exactly one execute cycle. On a store it samples the ALU output into a result register.

## Interface
- `N`, 16, datapath width (instruction, ALU operand, ALU result)
- `M`, 3, ALU select width
- `PC_W`, 8, program counter / instruction address width

- `clk`  in  1  system clock; all state changes on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  single-cycle pulse; leaves IDLE; ignored in any other state
- `imem_addr`  out  PC_W  instruction address, equal to `pc`
- `imem_req`  out  1  fetch request
- `imem_ack`  in  1  memory has `imem_data` valid this cycle
- `imem_data`  in  N  instruction word
- `alu_in`  out  N  ALU operand: instruction bits [11:0], zero-extended
- `alu_select`  out  M  ALU select
- `alu_enable`  out  1  ALU update strobe
- `alu_out`  in  N  ALU output; valid only while `alu_select[2]`=1
- `result`  out  N  last value captured by STORE
- `result_valid`  out  1  one-cycle pulse when `result` updates
- `halted`  out  1  sticky; high in HALT
- `illegal`  out  1  sticky; an undefined opcode was executed

## Operation
- Instruction format: [15:12] opcode, [11:0] immediate.
- Opcodes:
  - 0 NOP
  - 1 ADD imm: select 000, enable 1
  - 2 SUB imm: select 001, enable 1
  - 3 INC: select 010, enable 1
  - 4 DEC: select 011, enable 1
  - 5 STORE: select 100, enable 0, `result` <= `alu_out`
  - 6 JMP imm: `pc` <= imm[PC_W-1:0]
  - F HALT
  - 7–E: execute as NOP and set `illegal`
- States:
  - IDLE: `start` -> FETCH.
  - FETCH: `imem_req`=1 and `imem_addr` held stable. `imem_ack` at an edge latches `imem_data` into the instruction register -> DECODE; otherwise stay in FETCH.
  - DECODE: `pc` <= `pc`+1, modulo 2^PC_W, so 255 wraps to 0. Registered ALU controls are loaded -> EXEC.
  - EXEC: ALU controls are presented for exactly this one cycle -> FETCH, or -> HALT for opcode F.
  - HALT: terminal; only `rst` exits.
- Outside EXEC: `alu_enable`=0, `alu_select`=000, `alu_in`=0.
- `imem_req` is high only in FETCH. It drops in the cycle after the ack edge.
- JMP: its target overrides the DECODE increment. The next fetch address is the target.
- STORE: `result` captures `alu_out` at the end-of-EXEC edge. `result_valid` is high for the following cycle.
- Reset value of every output: `pc`/`imem_addr`=0, `imem_req`=0, `alu_in`=0, `alu_select`=000, `alu_enable`=0, `result`=0, `result_valid`=0, `halted`=0, `illegal`=0. State is IDLE.

## Timing
- All outputs are registered, so there are no combinational paths from inputs to outputs.
- With `imem_ack` high in the first FETCH cycle, one instruction takes 3 cycles (FETCH, DECODE, EXEC). Each cycle `imem_ack` stays low adds 1 cycle.
- An arithmetic op enters the ALU accumulator at the end-of-EXEC edge. A STORE immediately after sees the updated value.
- `imem_ack` outside FETCH is ignored and latches nothing.
- `rst` asserted mid-fetch forces `imem_req` low asynchronously. A pending ack is discarded.
- `start` coincident with `rst` is ignored.

## Structure
- Package `acc_seq_pkg` holds:
  - opcode localparams (OP_NOP … OP_HALT)
  - ALU select constants (SEL_ADD=000, SEL_SUB=001, SEL_INC=010, SEL_DEC=011, SEL_READ=100)
  - the state encoding
- Sub-module `acc_instr_decode` is purely combinational: opcode -> {select, enable, is_store, is_jump, is_halt, is_illegal}. The FSM top registers its outputs.

## Test plan
- Reset, then `start`, program ADD 5; STORE; HALT, ack same cycle -> `result`=0x0005 pulsed `result_valid` at cycle 6; `halted`=1 after cycle 9.
- ADD 0xFFF; INC; STORE -> `result`=0x1000; `alu_enable` high exactly 2 cycles total.
- Hold `imem_ack` low 4 cycles on the first fetch -> `imem_addr`=0 and `imem_req` stable throughout; the instruction latches only on the ack edge.
- JMP 0x20 at address 0xFF -> next `imem_addr`=0x20 (not 0x00). Separately, NOP at 0xFF -> next `imem_addr`=0x00.
- Opcode 0x9 -> `illegal`=1, no ALU enable, execution continues.
- Assert `rst` during FETCH with `imem_ack` pending -> all outputs return to their reset values immediately; `start` is needed to resume from `pc`=0.

Source files
------------

// File: rtl/acc_seq_pkg.sv
// rtl/acc_seq_pkg.sv - opcodes, ALU selects, FSM states and decode bundle for acc_sequencer
package acc_seq_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_INC   = 4'h3;
  localparam logic [3:0] OP_DEC   = 4'h4;
  localparam logic [3:0] OP_STORE = 4'h5;
  localparam logic [3:0] OP_JMP   = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [2:0] SEL_ADD  = 3'b000;
  localparam logic [2:0] SEL_SUB  = 3'b001;
  localparam logic [2:0] SEL_INC  = 3'b010;
  localparam logic [2:0] SEL_DEC  = 3'b011;
  localparam logic [2:0] SEL_READ = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALT
  } state_t;

  typedef struct packed {
    logic [2:0] select;
    logic       enable;
    logic       is_store;
    logic       is_jump;
    logic       is_halt;
    logic       is_illegal;
  } dec_t;

endpackage

// File: rtl/acc_instr_decode.sv
// rtl/acc_instr_decode.sv - combinational opcode decoder feeding the sequencer FSM
module acc_instr_decode
  import acc_seq_pkg::*;
(
  input  logic [3:0] opcode,
  output dec_t       dec
);

  always_comb begin
    dec        = '0;
    dec.select = SEL_ADD;
    case (opcode)
      OP_NOP:   ;
      OP_ADD:   begin dec.select = SEL_ADD;  dec.enable = 1'b1; end
      OP_SUB:   begin dec.select = SEL_SUB;  dec.enable = 1'b1; end
      OP_INC:   begin dec.select = SEL_INC;  dec.enable = 1'b1; end
      OP_DEC:   begin dec.select = SEL_DEC;  dec.enable = 1'b1; end
      OP_STORE: begin dec.select = SEL_READ; dec.is_store = 1'b1; end
      OP_JMP:   dec.is_jump = 1'b1;
      OP_HALT:  dec.is_halt = 1'b1;
      default:  dec.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/acc_sequencer.sv
// rtl/acc_sequencer.sv - fetch/decode/execute sequencer driving the accumulator ALU
module acc_sequencer
  import acc_seq_pkg::*;
#(
  parameter int N    = 16,
  parameter int M    = 3,
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [N-1:0]    imem_data,
  output logic [N-1:0]    alu_in,
  output logic [M-1:0]    alu_select,
  output logic            alu_enable,
  input  logic [N-1:0]    alu_out,
  output logic [N-1:0]    result,
  output logic            result_valid,
  output logic            halted,
  output logic            illegal
);

  state_t          state, state_nx;
  logic [N-1:0]    ir;
  logic [PC_W-1:0] pc;
  dec_t            dec;

  // ir is stable from DECODE through EXEC, so one decoder serves both
  acc_instr_decode u_decode (
    .opcode (ir[N-1 -: 4]),
    .dec    (dec)
  );

  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (start) state_nx = ST_FETCH;
      ST_FETCH:  if (imem_ack) state_nx = ST_DECODE;
      ST_DECODE: state_nx = ST_EXEC;
      ST_EXEC:   state_nx = dec.is_halt ? ST_HALT : ST_FETCH;
      ST_HALT:   state_nx = ST_HALT;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= '0;
      ir           <= '0;
      imem_req     <= 1'b0;
      alu_in       <= '0;
      alu_select   <= '0;
      alu_enable   <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      halted       <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      // ALU controls live for exactly the EXEC cycle; cleared on every other edge
      imem_req     <= (state_nx == ST_FETCH);
      result_valid <= 1'b0;
      alu_in       <= '0;
      alu_select   <= '0;
      alu_enable   <= 1'b0;
      case (state)
        ST_FETCH: if (imem_ack) ir <= imem_data;
        ST_DECODE: begin
          pc         <= dec.is_jump ? ir[PC_W-1:0] : pc + 1'b1;
          alu_in     <= N'(ir[11:0]);
          alu_select <= M'(dec.select);
          alu_enable <= dec.enable;
        end
        ST_EXEC: begin
          if (dec.is_store) begin
            result       <= alu_out;
            result_valid <= 1'b1;
          end
          if (dec.is_illegal) illegal <= 1'b1;
          if (dec.is_halt)    halted  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
